// File: rtl/vga_controller.sv
// VGA 640x480@60 timing generator with renderer request port and DAC drive.
// Sync, blank and colour leave a two-stage pipeline so they stay aligned.
module vga_controller #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_read,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    input  logic [1:0] R,
    input  logic [1:0] G,
    input  logic [1:0] B,
    output logic       frame_start,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] H_SB   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] V_SB   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    logic [DW-1:0] div_cnt;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          tick;
    logic          visible;
    logic          hs1;
    logic          vs1;
    logic          vis1;
    logic          valid1;

    assign tick        = (div_cnt == DIV_LAST);
    assign visible     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign pixel_read  = !reset && tick && visible;
    assign frame_start = !reset && tick && (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign pixel_x     = h_cnt;
    assign pixel_y     = v_cnt;
    assign VGA_SYNC_N  = 1'b0;

    // Pixel-rate divider: one tick cycle every CLK_DIV system clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // DAC clock: high during the second half of each pixel period.
    always_ff @(posedge clk) begin
        if (reset) begin
            VGA_CLK <= 1'b0;
        end else begin
            VGA_CLK <= (div_cnt >= DIV_HALF);
        end
    end

    // Raster position; the line wrap carries into the frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Stage 1: capture sync/blank for the pixel just requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid1 <= 1'b0;
            hs1    <= 1'b1;
            vs1    <= 1'b1;
            vis1   <= 1'b0;
        end else begin
            valid1 <= tick;
            if (tick) begin
                hs1  <= !((h_cnt >= H_SB) && (h_cnt < H_SE));
                vs1  <= !((v_cnt >= V_SB) && (v_cnt < V_SE));
                vis1 <= visible;
            end
        end
    end

    // Stage 2: merge the renderer colour with the delayed sync/blank.
    always_ff @(posedge clk) begin
        if (reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
        end else if (valid1) begin
            VGA_HS      <= hs1;
            VGA_VS      <= vs1;
            VGA_BLANK_N <= vis1;
            if (vis1) begin
                VGA_R <= {4{R}};
                VGA_G <= {4{G}};
                VGA_B <= {4{B}};
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller on a shrunken raster so whole frames run quickly.
// Reference raster is derived from elapsed cycles; DAC values go via a queue.
module tb_vga_controller;

    localparam int DIV = 2;
    localparam int HV  = 16;
    localparam int HF  = 2;
    localparam int HSY = 3;
    localparam int HB  = 2;
    localparam int VV  = 6;
    localparam int VF  = 1;
    localparam int VSY = 2;
    localparam int VB  = 1;
    localparam int HT  = HV + HF + HSY + HB;
    localparam int VT  = VV + VF + VSY + VB;

    logic       clk = 1'b0;
    logic       reset;
    logic       pixel_read;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [1:0] R = 2'b00;
    logic [1:0] G = 2'b00;
    logic [1:0] B = 2'b00;
    logic       frame_start;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       VGA_CLK;

    vga_controller #(
        .CLK_DIV(DIV), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY),
        .H_BACK(HB), .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY),
        .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .pixel_read(pixel_read),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .R(R), .G(G), .B(B),
        .frame_start(frame_start), .VGA_R(VGA_R), .VGA_G(VGA_G),
        .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
        .VGA_CLK(VGA_CLK)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         mode;
        logic [1:0] r, g, b;
        logic [7:0] er, eg, eb;
    } vec_t;

    typedef struct {
        logic       hs, vs, bl;
        logic [7:0] r, g, b;
    } dac_t;

    vec_t tbl [4];
    dac_t q [$];
    dac_t cur;
    dac_t nx;
    logic [7:0] rep [4];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit armed   = 0;
    int mode    = 0;
    logic [1:0] cur_r, cur_g, cur_b;
    logic [7:0] cur_er, cur_eg, cur_eb;
    logic [5:0] resp = 6'b0;

    int p, h, v;
    bit tk, vis;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply_vec(input int i);
        mode   = tbl[i].mode;
        cur_r  = tbl[i].r;
        cur_g  = tbl[i].g;
        cur_b  = tbl[i].b;
        cur_er = tbl[i].er;
        cur_eg = tbl[i].eg;
        cur_eb = tbl[i].eb;
    endtask

    // Renderer model: answer one clk after each strobe, junk otherwise.
    always @(negedge clk) begin
        if (pixel_read === 1'b1) begin
            if (mode == 1)
                resp = {pixel_x[1:0], pixel_x[1:0], pixel_x[1:0]};
            else
                resp = {cur_r, cur_g, cur_b};
        end else begin
            resp = 6'b111111;
        end
    end

    always @(posedge clk) begin
        #1;
        {R, G, B} = resp;
    end

    // Cycle count since the last edge that saw reset.
    always @(posedge clk) begin
        if (reset) begin
            cyc   = 0;
            armed = 1;
            q.delete();
            cur = '{hs: 1'b1, vs: 1'b1, bl: 1'b0, r: 8'h0, g: 8'h0, b: 8'h0};
        end else if (armed) begin
            cyc++;
        end
    end

    // Reference raster and output scoreboard.
    always @(negedge clk) begin
        if (armed) begin
            p   = cyc / DIV;
            h   = p % HT;
            v   = (p / HT) % VT;
            tk  = (cyc % DIV) == DIV - 1;
            vis = (h < HV) && (v < VV);
            if (cyc >= 2 && ((cyc - 2) % DIV) == DIV - 1) begin
                if (q.size() == 0) chk("sb_empty", 0, 1);
                else cur = q.pop_front();
            end
            if (tk && !reset) begin
                nx.hs = !(h >= HV + HF && h < HV + HF + HSY);
                nx.vs = !(v >= VV + VF && v < VV + VF + VSY);
                nx.bl = vis;
                if (!vis) begin
                    nx.r = 8'h0; nx.g = 8'h0; nx.b = 8'h0;
                end else if (mode == 1) begin
                    nx.r = rep[h % 4]; nx.g = rep[h % 4]; nx.b = rep[h % 4];
                end else begin
                    nx.r = cur_er; nx.g = cur_eg; nx.b = cur_eb;
                end
                q.push_back(nx);
            end
            chk("pixel_x", pixel_x, h);
            chk("pixel_y", pixel_y, v);
            chk("pixel_read", pixel_read, tk && vis && !reset);
            chk("frame_start", frame_start, tk && h == 0 && v == 0 && !reset);
            chk("vga_clk", VGA_CLK,
                (cyc == 0) ? 0 : (((cyc - 1) % DIV) >= DIV / 2));
            chk("sync_n", VGA_SYNC_N, 0);
            chk("vga_hs", VGA_HS, cur.hs);
            chk("vga_vs", VGA_VS, cur.vs);
            chk("blank_n", VGA_BLANK_N, cur.bl);
            chk("vga_r", VGA_R, cur.r);
            chk("vga_g", VGA_G, cur.g);
            chk("vga_b", VGA_B, cur.b);
        end
    end

    task automatic wait_fs(output bit ok);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1;
                break;
            end
        end
        chk("fs_wait", ok, 1);
    endtask

    task automatic measure_frame();
        bit ok;
        bit done;
        int n, prc, hsl, vsl;
        wait_fs(ok);
        if (!ok) return;
        n = 1; prc = pixel_read; hsl = !VGA_HS; vsl = !VGA_VS;
        done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (frame_start) begin
                done = 1;
            end else begin
                n++;
                prc += pixel_read;
                hsl += !VGA_HS;
                vsl += !VGA_VS;
            end
        end
        chk("frame_done", done, 1);
        if (done) begin
            chk("frame_period", n, HT * VT * DIV);
            chk("pr_per_frame", prc, HV * VV);
            chk("hs_low_clks", hsl, HSY * DIV * VT);
            chk("vs_low_clks", vsl, VSY * HT * DIV);
        end
    endtask

    initial begin
        bit ok;
        int first;
        reset = 1'b1;
        rep[0] = 8'h00; rep[1] = 8'h55; rep[2] = 8'hAA; rep[3] = 8'hFF;
        tbl[0] = '{mode: 0, r: 2'b11, g: 2'b00, b: 2'b10,
                   er: 8'hFF, eg: 8'h00, eb: 8'hAA};
        tbl[1] = '{mode: 0, r: 2'b01, g: 2'b10, b: 2'b11,
                   er: 8'h55, eg: 8'hAA, eb: 8'hFF};
        tbl[2] = '{mode: 0, r: 2'b00, g: 2'b01, b: 2'b00,
                   er: 8'h00, eg: 8'h55, eb: 8'h00};
        tbl[3] = '{mode: 1, r: 2'b00, g: 2'b00, b: 2'b00,
                   er: 8'h00, eg: 8'h00, eb: 8'h00};
        apply_vec(0);

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        first = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (pixel_read && first < 0) begin
                first = cyc;
                chk("first_fs", frame_start, 1);
                chk("first_px", pixel_x, 0);
            end
            if (cyc == 2) chk("blank_c2", VGA_BLANK_N, 0);
            if (cyc == 3) chk("blank_c3", VGA_BLANK_N, 1);
        end
        chk("first_pr_cyc", first, 1);

        measure_frame();

        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2 apply_vec(i);
            repeat (2) wait_fs(ok);
        end

        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pixel_read && pixel_x == 10 && pixel_y == 3) begin
                ok = 1;
                break;
            end
        end
        chk("mid_trigger", ok, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rst_hs", VGA_HS, 1);
        chk("rst_vs", VGA_VS, 1);
        chk("rst_blank", VGA_BLANK_N, 0);
        chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 0);
        chk("rst_pos", {pixel_x, pixel_y}, 0);
        chk("rst_vclk", VGA_CLK, 0);
        @(negedge clk);
        chk("restart_fs", frame_start, 1);
        chk("restart_pr", pixel_read, 1);
        @(negedge clk);
        chk("no_stale_r", VGA_R, 0);

        measure_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_controller.md
Name: vga_controller

Overview:
- Generates 640x480@60 Hz VGA timing from the system clock.
- Drives the pixel request side of the renderer interface: pixel_x, pixel_y and a one-clock pixel_read strobe.
- Captures the renderer's 2-bit R/G/B response and drives the board's 8-bit VGA DAC pins, with sync and blank aligned to the colour.
- Sits between the renderer and the top-level VGA pins.

Parameters:
CLK_DIV, 2, system clocks per pixel (50 MHz clk gives a 25 MHz pixel rate); must be >= 2
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch in pixels
H_SYNC, 96, hsync pulse width in pixels
H_BACK, 48, horizontal back porch in pixels
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch in lines
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch in lines

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pixel_read  out  1  one-clk strobe; the renderer must produce colour for (pixel_x, pixel_y)
pixel_x  out  10  current horizontal counter h_cnt
pixel_y  out  10  current vertical counter v_cnt
R  in  2  renderer red, valid the clk after pixel_read
G  in  2  renderer green, same timing as R
B  in  2  renderer blue, same timing as R
frame_start  out  1  one-clk pulse when the counters enter (0,0)
VGA_R  out  8  red to DAC
VGA_G  out  8  green to DAC
VGA_B  out  8  blue to DAC
VGA_HS  out  1  hsync, active low
VGA_VS  out  1  vsync, active low
VGA_BLANK_N  out  1  low outside the visible area
VGA_SYNC_N  out  1  constant 0
VGA_CLK  out  1  pixel clock to the DAC

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Divider div_cnt runs 0..CLK_DIV-1 and wraps.
  - tick = (div_cnt == CLK_DIV-1).
  - VGA_CLK = (div_cnt >= CLK_DIV/2), registered.
- Counters advance only at the clk edge that ends a tick cycle.
  - h_cnt increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0.
- pixel_x = h_cnt and pixel_y = v_cnt at all times, including blanking.
- pixel_read = tick && visible, combinational from registered state; high for exactly one clk per visible pixel.
  - visible = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- frame_start = tick && h_cnt==0 && v_cnt==0; one clk per frame.
- Stage 1, at the edge ending the tick cycle, registers:
  - hs1 = !(h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC))
  - vs1 = !(v_cnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC))
  - vis1 = visible
  - valid1 = 1; on every other clk valid1 = 0.
- Stage 2, at the next edge if valid1:
  - VGA_HS = hs1, VGA_VS = vs1, VGA_BLANK_N = vis1.
  - If vis1: VGA_R = {4{R}}, i.e. the 2-bit value replicated (11 -> 0xFF, 10 -> 0xAA, 01 -> 0x55, 00 -> 0x00); same for G and B.
  - Else the colour outputs are 0.
  - Outputs hold until the next valid1.
- Latency: DAC outputs update 2 clk edges after the start of the pixel_read cycle and are stable for CLK_DIV clk.
- R/G/B are sampled only when valid1 && vis1; their values at other times are ignored.
- Reset (synchronous) forces:
  - div_cnt=0, h_cnt=0, v_cnt=0, valid1=0.
  - pixel_read=0 and frame_start=0 (both gated by !reset).
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0, VGA_CLK=0.
- Reset mid-frame:
  - Discards the pipeline; no colour from an in-flight pixel reaches the outputs.
  - The first tick after release is (0,0) with frame_start.
- Simultaneous h and v wrap at (H_TOTAL-1, V_TOTAL-1): both counters go to 0 on the same edge.

Test Plan:
- Release reset at cycle 0 with CLK_DIV=2 -> first pixel_read and frame_start both in cycle 1 with pixel_x=0, pixel_y=0; VGA_BLANK_N rises at edge ending cycle 2.
- Run one line -> exactly 640 pixel_read strobes, 1600 clk apart line-to-line; VGA_HS low for 192 clk, starting 1312 clk after the output of pixel 0; no pixel_read for h_cnt 640..799.
- Run a full frame -> frame_start period 840000 clk; VGA_VS low for 3200 clk, starting at line 490; 307200 pixel_read strobes per frame.
- Renderer model answers R=11, G=00, B=10 one clk after each pixel_read -> VGA_R=0xFF, VGA_G=0x00, VGA_B=0xAA while BLANK_N=1; R/G/B forced to 11 during porches -> all VGA colour outputs 0.
- Renderer model answers colour = pixel_x[1:0] -> VGA_R sequence 00,55,AA,FF repeats, each value held 2 clk, aligned with BLANK_N.
- Assert reset 1 clk at (h=300, v=200) -> outputs take reset values next edge; after release, counters restart at (0,0) with frame_start; no stale colour emitted.
